// File: rtl/video_stream_aligner_pkg.sv
// Shared constants and the delay-clamping helper for the video stream aligner.
package video_stream_aligner_pkg;

    localparam int unsigned DEFAULT_DELAY = 6;
    localparam int unsigned A_W           = 8;
    localparam int unsigned DELAY_W       = 7;

    // A zero delay would select a stage that does not exist, so it is raised to 1.
    function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] req,
                                                       input int unsigned        max_delay);
        logic [DELAY_W-1:0] max_v;
        max_v = DELAY_W'(max_delay);
        if (req == '0) begin
            return DELAY_W'(1);
        end
        if (req > max_v) begin
            return max_v;
        end
        return req;
    endfunction

endpackage

// File: rtl/video_stream_aligner_if.sv
// Source, transmission-map and atmospheric-light streams entering and leaving the aligner.
interface video_stream_aligner_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned TX_W   = 8
);
    import video_stream_aligner_pkg::*;

    logic              per_src_frame_vsync;
    logic              per_src_frame_href;
    logic              per_src_frame_clken;
    logic [DATA_W-1:0] per_img;

    logic              per_tx_frame_vsync;
    logic              per_tx_frame_href;
    logic              per_tx_frame_clken;
    logic [TX_W-1:0]   per_tx_img;

    logic [A_W-1:0]    per_A;

    logic              post_src_frame_vsync;
    logic              post_src_frame_href;
    logic              post_src_frame_clken;
    logic [DATA_W-1:0] post_img;

    logic              post_tx_frame_vsync;
    logic              post_tx_frame_href;
    logic              post_tx_frame_clken;
    logic [TX_W-1:0]   post_tx_img;

    logic [A_W-1:0]    post_A;

    modport master (
        output per_src_frame_vsync, per_src_frame_href, per_src_frame_clken, per_img,
        output per_tx_frame_vsync, per_tx_frame_href, per_tx_frame_clken, per_tx_img,
        output per_A,
        input  post_src_frame_vsync, post_src_frame_href, post_src_frame_clken, post_img,
        input  post_tx_frame_vsync, post_tx_frame_href, post_tx_frame_clken, post_tx_img,
        input  post_A
    );

    modport slave (
        input  per_src_frame_vsync, per_src_frame_href, per_src_frame_clken, per_img,
        input  per_tx_frame_vsync, per_tx_frame_href, per_tx_frame_clken, per_tx_img,
        input  per_A,
        output post_src_frame_vsync, post_src_frame_href, post_src_frame_clken, post_img,
        output post_tx_frame_vsync, post_tx_frame_href, post_tx_frame_clken, post_tx_img,
        output post_A
    );

endinterface

// File: rtl/video_stream_aligner_tap_delay_line.sv
// Fixed-depth shift register with a run-time selectable output tap (tap 0 = 1 cycle latency).
module tap_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [TAP_W-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Out-of-range taps read as zero rather than indexing past the chain.
    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (int'(tap) == i) begin
                dout = stage_q[i];
            end
        end
    end

endmodule

// File: rtl/video_stream_aligner.sv
// Delays the source stream to line up with the transmission map, latches A once per output
// frame and counts cycles where the two streams' timing disagrees.
module video_stream_aligner
    import video_stream_aligner_pkg::*;
#(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned TX_W      = 8,
    parameter int unsigned MAX_DELAY = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DELAY_W-1:0]    cfg_delay,
    video_stream_aligner_if.slave bus,
    output logic [DELAY_W-1:0]    active_delay,
    output logic                  align_err,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int unsigned LINE_W = DATA_W + 3;
    localparam int unsigned TAP_W  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [DELAY_W-1:0] RESET_DELAY =
        DELAY_W'((DEFAULT_DELAY < MAX_DELAY) ? DEFAULT_DELAY : MAX_DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LINE_W-1:0]  line_in;
    logic [LINE_W-1:0]  line_out;
    logic [TAP_W-1:0]   tap;
    logic [TX_W-1:0]    tx_img;

    logic               src_vsync_q;
    logic               post_vsync_q;
    logic               src_rise;
    logic               post_rise;
    logic               mismatch;
    logic [DELAY_W-1:0] active_delay_q, active_delay_d;
    logic [A_W-1:0]     post_a_q, post_a_d;
    logic               align_err_q, align_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Transmission stream is already aligned by construction; it is only forwarded.
    assign tx_img                  = bus.per_tx_img;
    assign bus.post_tx_img         = tx_img;
    assign bus.post_tx_frame_vsync = bus.per_tx_frame_vsync;
    assign bus.post_tx_frame_href  = bus.per_tx_frame_href;
    assign bus.post_tx_frame_clken = bus.per_tx_frame_clken;

    assign line_in = {bus.per_src_frame_vsync, bus.per_src_frame_href,
                      bus.per_src_frame_clken, bus.per_img};
    assign tap     = TAP_W'(active_delay_q - DELAY_W'(1));

    tap_delay_line #(
        .WIDTH (LINE_W),
        .DEPTH (MAX_DELAY),
        .TAP_W (TAP_W)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (line_in),
        .tap  (tap),
        .dout (line_out)
    );

    assign {bus.post_src_frame_vsync, bus.post_src_frame_href,
            bus.post_src_frame_clken, bus.post_img} = line_out;

    always_comb begin
        src_rise  = bus.per_src_frame_vsync & ~src_vsync_q;
        post_rise = bus.post_src_frame_vsync & ~post_vsync_q;
        mismatch  = (bus.post_src_frame_href != bus.per_tx_frame_href) |
                    (bus.post_src_frame_clken != bus.per_tx_frame_clken);

        active_delay_d = active_delay_q;
        if (src_rise) begin
            active_delay_d = clamp_delay(cfg_delay, MAX_DELAY);
        end

        post_a_d = post_a_q;
        if (post_rise) begin
            post_a_d = bus.per_A;
        end

        align_err_d = align_err_q | mismatch;

        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // Edge detectors clear to "previous = 0" so vsync held high through reset counts as a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_vsync_q    <= 1'b0;
            post_vsync_q   <= 1'b0;
            active_delay_q <= RESET_DELAY;
            post_a_q       <= '0;
            align_err_q    <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            src_vsync_q    <= bus.per_src_frame_vsync;
            post_vsync_q   <= bus.post_src_frame_vsync;
            active_delay_q <= active_delay_d;
            post_a_q       <= post_a_d;
            align_err_q    <= align_err_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign active_delay = active_delay_q;
    assign bus.post_A   = post_a_q;
    assign align_err    = align_err_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_video_stream_aligner.sv
// Directed frame sequences for the video stream aligner with a cycle-level expectation model.
module tb_video_stream_aligner;
    import video_stream_aligner_pkg::*;

    localparam int unsigned DATA_W    = 24;
    localparam int unsigned TX_W      = 8;
    localparam int unsigned MAX_DELAY = 16;
    localparam int          HIST      = 1024;

    logic               clk = 1'b0;
    logic               rst;
    logic [DELAY_W-1:0] cfg_delay;
    logic [DELAY_W-1:0] active_delay;
    logic [DELAY_W-1:0] active_delay_s;
    logic               align_err;
    logic               align_err_s;
    logic [15:0]        err_cnt;
    logic [1:0]         err_cnt_s;

    video_stream_aligner_if #(.DATA_W(DATA_W), .TX_W(TX_W)) bus ();
    video_stream_aligner_if #(.DATA_W(DATA_W), .TX_W(TX_W)) bus_s ();

    // The narrow-counter instance sees exactly the same stimulus.
    assign bus_s.per_src_frame_vsync = bus.per_src_frame_vsync;
    assign bus_s.per_src_frame_href  = bus.per_src_frame_href;
    assign bus_s.per_src_frame_clken = bus.per_src_frame_clken;
    assign bus_s.per_img             = bus.per_img;
    assign bus_s.per_tx_frame_vsync  = bus.per_tx_frame_vsync;
    assign bus_s.per_tx_frame_href   = bus.per_tx_frame_href;
    assign bus_s.per_tx_frame_clken  = bus.per_tx_frame_clken;
    assign bus_s.per_tx_img          = bus.per_tx_img;
    assign bus_s.per_A               = bus.per_A;

    video_stream_aligner #(
        .DATA_W    (DATA_W),
        .TX_W      (TX_W),
        .MAX_DELAY (MAX_DELAY),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_delay    (cfg_delay),
        .bus          (bus),
        .active_delay (active_delay),
        .align_err    (align_err),
        .err_cnt      (err_cnt)
    );

    video_stream_aligner #(
        .DATA_W    (DATA_W),
        .TX_W      (TX_W),
        .MAX_DELAY (MAX_DELAY),
        .CNT_W     (2)
    ) dut_s (
        .clk          (clk),
        .rst          (rst),
        .cfg_delay    (cfg_delay),
        .bus          (bus_s),
        .active_delay (active_delay_s),
        .align_err    (align_err_s),
        .err_cnt      (err_cnt_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DATA_W-1:0] h_img [HIST];
    logic              h_v   [HIST];
    logic              h_h   [HIST];
    logic              h_c   [HIST];
    logic              e_hst [HIST];

    int         lat        = int'(DEFAULT_DELAY);
    int         valid_from = 0;
    int         cfg_req    = 6;
    logic       src_prev   = 1'b0;
    logic       e_vprev    = 1'b0;
    logic [7:0] e_a        = 8'd0;
    logic       e_err      = 1'b0;
    int         e_cnt      = 0;
    int         e_cnt_s    = 0;
    logic       skew       = 1'b0;
    logic       auto_chk   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int clampb(input int d);
        if (d == 0) return 1;
        if (d > int'(MAX_DELAY)) return int'(MAX_DELAY);
        return d;
    endfunction

    // One clock cycle: apply inputs, drive the ideally aligned tx stream, check, advance model.
    task automatic drive(input logic r, input logic v, input logic h, input logic c);
        logic [DATA_W-1:0] ei;
        logic              ev, eh, ec, txh, mm;
        logic [7:0]        a;
        int                src;
        @(posedge clk);
        #1;
        rst       = r;
        cfg_delay = DELAY_W'(cfg_req);
        a         = 8'(cyc * 37 + 5);
        bus.per_src_frame_vsync = v;
        bus.per_src_frame_href  = h;
        bus.per_src_frame_clken = c;
        bus.per_img             = DATA_W'(32'h00A0_0000 + cyc * 3);
        bus.per_A               = a;
        src = cyc - lat;
        if (src >= valid_from && src >= 0) begin
            {ev, eh, ec, ei} = {h_v[src], h_h[src], h_c[src], h_img[src]};
        end else begin
            {ev, eh, ec, ei} = '0;
        end
        h_v[cyc]   = v;
        h_h[cyc]   = h;
        h_c[cyc]   = c;
        h_img[cyc] = bus.per_img;
        e_hst[cyc] = eh;
        txh = (skew && cyc > 0) ? e_hst[cyc-1] : eh;
        bus.per_tx_frame_vsync = ev;
        bus.per_tx_frame_href  = txh;
        bus.per_tx_frame_clken = ec;
        bus.per_tx_img         = 8'(cyc);
        mm = (txh != eh);
        #2;
        if (auto_chk) begin
            check("post_src", 64'({bus.post_src_frame_vsync, bus.post_src_frame_href,
                                   bus.post_src_frame_clken, bus.post_img}),
                  64'({ev, eh, ec, ei}));
            check("active_delay", 64'(active_delay), 64'(lat));
            check("post_tx", 64'({bus.post_tx_frame_vsync, bus.post_tx_frame_href,
                                  bus.post_tx_frame_clken, bus.post_tx_img}),
                  64'({ev, txh, ec, 8'(cyc)}));
            check("post_A", 64'(bus.post_A), 64'(e_a));
            check("align_err", 64'(align_err), 64'(e_err));
            check("err_cnt", 64'(err_cnt), 64'(e_cnt));
            check("err_cnt_sat", 64'(err_cnt_s), 64'(e_cnt_s));
        end
        if (r) begin
            lat        = int'(DEFAULT_DELAY);
            valid_from = cyc + 1;
            src_prev   = 1'b0;
            e_vprev    = 1'b0;
            e_a        = 8'd0;
            e_err      = 1'b0;
            e_cnt      = 0;
            e_cnt_s    = 0;
        end else begin
            if (v && !src_prev) lat = clampb(cfg_req);
            src_prev = v;
            if (ev && !e_vprev) e_a = a;
            e_vprev = ev;
            if (mm) begin
                e_err = 1'b1;
                if (e_cnt < 65535) e_cnt++;
                if (e_cnt_s < 3) e_cnt_s++;
            end
        end
        cyc++;
    endtask

    // Lines of 4 valid pixels separated by 2 idle cycles, then vsync-low blanking.
    task automatic send_body(input int lines, input int blank, input int mid_cfg);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < 4; p++) drive(1'b0, 1'b1, 1'b1, 1'b1);
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            if (l == 0 && mid_cfg >= 0) cfg_req = mid_cfg;
        end
        for (int b = 0; b < blank; b++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int lines, input int blank, input int mid_cfg);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_body(lines, blank, mid_cfg);
    endtask

    initial begin
        int r0;
        rst = 1'b1;
        cfg_delay = DELAY_W'(6);
        bus.per_src_frame_vsync = 1'b0;
        bus.per_src_frame_href  = 1'b0;
        bus.per_src_frame_clken = 1'b0;
        bus.per_img             = '0;
        bus.per_tx_frame_vsync  = 1'b0;
        bus.per_tx_frame_href   = 1'b0;
        bus.per_tx_frame_clken  = 1'b0;
        bus.per_tx_img          = '0;
        bus.per_A               = '0;

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        auto_chk = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_delay", 64'(active_delay), 64'd6);
        check("reset_err", 64'({align_err, err_cnt}), 64'd0);
        check("reset_post_A", 64'(bus.post_A), 64'd0);
        check("reset_post_img", 64'(bus.post_img), 64'd0);

        // 4x3 frame at delay 6; post vsync rises 6 cycles after the source rise.
        cfg_req = 6;
        r0 = cyc;
        send_frame(3, 20, -1);
        check("frame_delay6", 64'(active_delay), 64'd6);
        check("frame_post_A", 64'(bus.post_A), 64'(8'((r0 + 6) * 37 + 5)));

        // Request 3 mid-frame: held until the next source vsync rise.
        send_frame(3, 20, 3);
        check("mid_change_held", 64'(active_delay), 64'd6);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("delay_at_rise", 64'(active_delay), 64'd6);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("delay_after_rise", 64'(active_delay), 64'd3);
        send_body(3, 20, -1);

        cfg_req = 0;
        send_frame(3, 20, -1);
        check("clamp_low", 64'(active_delay), 64'd1);
        cfg_req = 100;
        send_frame(3, 20, -1);
        check("clamp_high", 64'(active_delay), 64'd16);

        // tx href lagging by one cycle: leading and trailing edge of each line mismatch.
        cfg_req = 6;
        skew = 1'b1;
        send_frame(1, 20, -1);
        check("skew_err_flag", 64'(align_err), 64'd1);
        check("skew_err_cnt", 64'(err_cnt), 64'd2);
        send_frame(3, 20, -1);
        skew = 1'b0;
        check("long_skew_cnt", 64'(err_cnt), 64'd8);
        check("sat_cnt", 64'(err_cnt_s), 64'd3);
        check("sat_flag", 64'(align_err_s), 64'd1);

        // One-cycle reset in the middle of a line.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_post_src", 64'({bus.post_src_frame_vsync, bus.post_src_frame_href,
                                   bus.post_src_frame_clken, bus.post_img}), 64'd0);
        check("rst_post_A", 64'(bus.post_A), 64'd0);
        check("rst_err", 64'({align_err, err_cnt}), 64'd0);
        check("rst_err_sat", 64'({align_err_s, err_cnt_s}), 64'd0);
        check("rst_delay", 64'(active_delay), 64'd6);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 20; b++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(3, 20, -1);
        check("resume_err", 64'(err_cnt), 64'd0);
        check("resume_delay_s", 64'(active_delay_s), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
